// File: rtl/bus_master_port.sv
// Pipelined bus master front-end: turns a valid/ready request stream into
// pipelined bus cycles, tracks outstanding requests, holds cyc across bursts
// and aborts (erroring every outstanding request) on bus error or watchdog.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package bus;
   typedef struct packed {
      logic                   cyc;
      logic                   stb;
      logic                   we;
      logic [`WORD_SIZE-3:0]  addr;
      logic [31:0]            data;
      logic [3:0]             sel;
   } m2s_s;

   typedef struct packed {
      logic        ack;
      logic        err;
      logic        stall;
      logic [31:0] data;
   } s2m_s;
endpackage

module bus_master_port #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [`WORD_SIZE-1:0]  req_addr,
   input  logic [31:0]            req_wdata,
   input  logic [3:0]             req_sel,
   output logic                   resp_valid,
   output logic [31:0]            resp_data,
   output logic                   resp_err,
   output bus::m2s_s              bus_o,
   input  bus::s2m_s              bus_i
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   // Watchdog only needs to reach TIMEOUT-1.
   localparam int WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit               WD_EN   = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_ABORT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [OUT_W-1:0]  r_out;
   logic [WD_W-1:0]   r_wd;

   logic w_active;
   logic w_stb;
   logic w_accept;
   logic w_done;
   logic w_err;
   logic w_expire;
   logic w_flush;
   logic w_unused_addr_lsb;

   // Byte offset within the word is not carried on the bus.
   assign w_unused_addr_lsb = ^req_addr[1:0];

   assign w_active = (r_state == S_ACTIVE);
   // stb gating by the outstanding limit is what keeps r_out from overflowing.
   assign w_stb    = w_active && req_valid && (r_out < OUT_MAX);
   assign w_accept = w_stb && !bus_i.stall;
   // Acks/errs count only while cyc is high and something is outstanding;
   // strays are dropped so the counter cannot underflow.
   assign w_done   = w_active && (r_out != '0) && (bus_i.ack || bus_i.err);
   assign w_err    = w_done && bus_i.err;
   assign w_expire = WD_EN && w_active && (r_out != '0) && !w_done && (r_wd == WD_LAST);
   assign w_flush  = (r_state == S_ABORT) && (r_out != '0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and combinational bus request outputs.
   always_comb begin
      w_state_nxt = r_state;
      bus_o       = '0;
      req_ready   = 1'b0;

      bus_o.cyc = w_active;
      bus_o.stb = w_stb;
      if (w_stb) begin
         bus_o.we   = req_we;
         bus_o.addr = req_addr[`WORD_SIZE-1:2];
         bus_o.data = req_wdata;
         bus_o.sel  = req_sel;
      end
      req_ready = w_accept;

      case (r_state)
         S_IDLE: begin
            if (req_valid) w_state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (w_err || w_expire)
               w_state_nxt = S_ABORT;
            else if ((r_out == '0) && !req_valid)
               w_state_nxt = S_IDLE;
         end
         S_ABORT: begin
            // Last flush (or nothing left) this cycle.
            if (r_out <= OUT_W'(1)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outstanding-request counter: +accept, -ack/err, -flush in ABORT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else if (w_active) begin
         if (w_accept && !w_done)      r_out <= r_out + OUT_W'(1);
         else if (!w_accept && w_done) r_out <= r_out - OUT_W'(1);
      end else if (w_flush) begin
         r_out <= r_out - OUT_W'(1);
      end
   end

   // Watchdog: counts cycles with requests pending and no ack/err.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd <= '0;
      end else if (!WD_EN || !w_active || w_done || (r_out == '0) || w_expire) begin
         r_wd <= '0;
      end else begin
         r_wd <= r_wd + WD_W'(1);
      end
   end

   // Registered response path: bus ack/err in ACTIVE, forced errors in ABORT.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_data  <= '0;
      end else if (w_done) begin
         resp_valid <= 1'b1;
         resp_err   <= bus_i.err;
         resp_data  <= bus_i.data;
      end else if (w_flush) begin
         resp_valid <= 1'b1;
         resp_err   <= 1'b1;
         resp_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
      end
   end

endmodule
